// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC capture controller:
//   - adc_state_e : controller state encoding (IDLE / WARMUP / RUN)
//   - div_of      : system-clock to ADC-clock division ratio
//   - div_legal   : DIV must be an exact, even ratio of at least 2
// ----------------------------------------------------------------------------
package adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } adc_state_e;

   function automatic int div_of(input int clk_mhz, input int adc_mhz);
      return (adc_mhz > 0) ? (clk_mhz / adc_mhz) : 0;
   endfunction

   function automatic bit div_legal(input int clk_mhz, input int adc_mhz);
      int d;
      if (adc_mhz <= 0) return 1'b0;
      d = clk_mhz / adc_mhz;
      return ((clk_mhz % adc_mhz) == 0) && (d >= 2) && ((d % 2) == 0);
   endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ----------------------------------------------------------------------------
// adc_clk_div
// Divides clk_PSRAM by DIV to produce the ADC conversion clock and a one-cycle
// tick on the last cycle of the low phase (just before adc_clk rises).
// Ports:
//   clk_PSRAM : system clock
//   rst       : synchronous active-high reset
//   active    : divider is running this cycle (controller not idle)
//   en_nx     : divider will be running next cycle
//   adc_clk   : registered ADC clock, high while div_cnt < DIV/2
//   tick      : div_cnt == DIV-1 while active
// ----------------------------------------------------------------------------
module adc_clk_div #(
   parameter int DIV = 10
) (
   input  logic clk_PSRAM,
   input  logic rst,
   input  logic active,
   input  logic en_nx,
   output logic adc_clk,
   output logic tick
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] div_cnt;
   logic [CW-1:0] cnt_nx;

   // The first active cycle always starts at 0, so counting restarts cleanly
   // on every enable.
   always_comb begin
      cnt_nx = '0;
      if (active && (div_cnt != CW'(DIV - 1)))
         cnt_nx = div_cnt + 1'b1;
   end

   // adc_clk is registered from the next count so it lines up with div_cnt
   // in the same cycle and stays glitch-free.
   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         div_cnt <= '0;
         adc_clk <= 1'b0;
      end else if (en_nx) begin
         div_cnt <= cnt_nx;
         adc_clk <= (cnt_nx < CW'(DIV / 2));
      end else begin
         div_cnt <= '0;
         adc_clk <= 1'b0;
      end
   end

   assign tick = active && (div_cnt == CW'(DIV - 1));

endmodule

// File: rtl/adc_capture_ctrl.sv
// ----------------------------------------------------------------------------
// adc_capture_ctrl
// Drives the ADC conversion clock, discards PIPE_DELAY pipeline-latency
// samples after each enable, captures adc_out/adc_OTR on each tick and
// optionally box-car averages 2^AVG_LOG2 samples. Results are offered through
// a single holding register with a valid/ready handshake.
// Ports:
//   clk_PSRAM, rst          : clock, synchronous active-high reset
//   adc_enable, avg_en      : run request, averaging mode (latched at start)
//   adc_out, adc_OTR        : ADC parallel data and out-of-range flag
//   adc_clk                 : generated ADC conversion clock
//   sample_valid/ready/data : output handshake and sample (or average)
//   sample_otr              : OTR seen in any contributing sample
//   overrun                 : sticky, a result was dropped
//   otr_count               : saturating count of captured OTR samples
//   stat_clr                : clears overrun and otr_count
//   busy                    : controller not idle
// ----------------------------------------------------------------------------
module adc_capture_ctrl
   import adc_pkg::*;
#(
   parameter int CLK        = 60,
   parameter int ADC_FREQ   = 6,
   parameter int DATA_W     = 12,
   parameter int PIPE_DELAY = 8,
   parameter int AVG_LOG2   = 2,
   parameter int OTR_CNT_W  = 16
) (
   input  logic                 clk_PSRAM,
   input  logic                 rst,
   input  logic                 adc_enable,
   input  logic                 avg_en,
   input  logic [DATA_W-1:0]    adc_out,
   input  logic                 adc_OTR,
   output logic                 adc_clk,
   output logic                 sample_valid,
   input  logic                 sample_ready,
   output logic [DATA_W-1:0]    sample_data,
   output logic                 sample_otr,
   output logic                 overrun,
   output logic [OTR_CNT_W-1:0] otr_count,
   input  logic                 stat_clr,
   output logic                 busy
);

   localparam int DIV      = div_of(CLK, ADC_FREQ);
   localparam int ACC_W    = DATA_W + AVG_LOG2;
   localparam int WC_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int WIN_LAST = (1 << AVG_LOG2) - 1;
   localparam int DC_W     = (PIPE_DELAY > 0) ? $clog2(PIPE_DELAY + 1) : 1;

   if (!div_legal(CLK, ADC_FREQ)) begin : g_div_check
      $error("adc_capture_ctrl: CLK/ADC_FREQ must be an exact even ratio >= 2");
   end

   function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
      return s[ACC_W-1:AVG_LOG2];
   endfunction

   function automatic logic [OTR_CNT_W-1:0] sat_inc(input logic [OTR_CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   adc_state_e        state, state_nx;
   logic [DC_W-1:0]   disc_cnt;
   logic              avg_q;
   logic [ACC_W-1:0]  acc;
   logic [WC_W-1:0]   win_cnt;
   logic              win_otr;
   logic              tick, active, en_nx, start, run_tick;

   assign active   = (state != ST_IDLE);
   assign en_nx    = (state_nx != ST_IDLE);
   assign start    = (state == ST_IDLE) && adc_enable;
   assign run_tick = tick && (state == ST_RUN);
   assign busy     = active;

   adc_clk_div #(.DIV(DIV)) u_div (
      .clk_PSRAM (clk_PSRAM),
      .rst       (rst),
      .active    (active),
      .en_nx     (en_nx),
      .adc_clk   (adc_clk),
      .tick      (tick)
   );

   always_ff @(posedge clk_PSRAM) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // With PIPE_DELAY=0 WARMUP lasts one cycle, which is always before the
   // first tick, so that tick is captured in RUN.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (adc_enable) state_nx = ST_WARMUP;
         ST_WARMUP: begin
            if (!adc_enable)
               state_nx = ST_IDLE;
            else if ((PIPE_DELAY == 0) || (tick && disc_cnt == DC_W'(PIPE_DELAY - 1)))
               state_nx = ST_RUN;
         end
         ST_RUN:    if (!adc_enable) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         disc_cnt <= '0;
         avg_q    <= 1'b0;
      end else if (start) begin
         disc_cnt <= '0;
         avg_q    <= avg_en;
      end else if (tick && state == ST_WARMUP) begin
         disc_cnt <= disc_cnt + 1'b1;
      end
   end

   // ---- stage 0: tick capture / window accumulation ----
   logic [ACC_W-1:0]  sum;
   logic              win_end;
   logic              res_vld;
   logic [DATA_W-1:0] res_data;
   logic              res_otr;

   always_comb begin
      sum      = acc + ACC_W'(adc_out);
      win_end  = (win_cnt == WC_W'(WIN_LAST));
      res_vld  = 1'b0;
      res_data = adc_out;
      res_otr  = adc_OTR;
      if (run_tick) begin
         if (!avg_q) begin
            res_vld = 1'b1;
         end else if (win_end) begin
            res_vld  = 1'b1;
            res_data = avg_trunc(sum);
            res_otr  = win_otr | adc_OTR;
         end
      end
   end

   // Leaving RUN/WARMUP (or starting) throws away any partial window.
   always_ff @(posedge clk_PSRAM) begin
      if (rst || start || !en_nx) begin
         acc     <= '0;
         win_cnt <= '0;
         win_otr <= 1'b0;
      end else if (run_tick && avg_q) begin
         if (win_end) begin
            acc     <= '0;
            win_cnt <= '0;
            win_otr <= 1'b0;
         end else begin
            acc     <= sum;
            win_cnt <= win_cnt + 1'b1;
            win_otr <= win_otr | adc_OTR;
         end
      end
   end

   // ---- stage 1: holding register and statistics ----
   logic take;
   assign take = !sample_valid || sample_ready;

   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_otr   <= 1'b0;
         overrun      <= 1'b0;
         otr_count    <= '0;
      end else begin
         if (res_vld && take) begin
            sample_valid <= 1'b1;
            sample_data  <= res_data;
            sample_otr   <= res_otr;
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end

         if (stat_clr)
            overrun <= 1'b0;
         else if (res_vld && !take)
            overrun <= 1'b1;

         if (stat_clr)
            otr_count <= '0;
         else if (run_tick && adc_OTR)
            otr_count <= sat_inc(otr_count);
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adc_capture_ctrl
// Directed bench for adc_capture_ctrl (DIV=10, PIPE_DELAY=8, AVG_LOG2=2,
// OTR_CNT_W=2). A per-tick source queue supplies adc_out/adc_OTR; a new entry
// is presented right after each adc_clk rise, so entry k is sampled on tick k.
// Cycle comments use Wn = n-th cycle after the controller leaves IDLE.
// ----------------------------------------------------------------------------
module tb_adc_capture_ctrl;

   localparam int DATA_W    = 12;
   localparam int OTR_CNT_W = 2;

   logic                 clk_PSRAM = 1'b0;
   logic                 rst, adc_enable, avg_en, adc_OTR, sample_ready, stat_clr;
   logic [DATA_W-1:0]    adc_out;
   logic                 adc_clk, sample_valid, sample_otr, overrun, busy;
   logic [DATA_W-1:0]    sample_data;
   logic [OTR_CNT_W-1:0] otr_count;

   int n_chk = 0;
   int n_err = 0;

   logic [DATA_W-1:0] q_d[$];
   logic              q_o[$];
   logic              clk_prev = 1'b0;

   adc_capture_ctrl #(
      .CLK(60), .ADC_FREQ(6), .DATA_W(DATA_W), .PIPE_DELAY(8),
      .AVG_LOG2(2), .OTR_CNT_W(OTR_CNT_W)
   ) dut (
      .clk_PSRAM    (clk_PSRAM),
      .rst          (rst),
      .adc_enable   (adc_enable),
      .avg_en       (avg_en),
      .adc_out      (adc_out),
      .adc_OTR      (adc_OTR),
      .adc_clk      (adc_clk),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .sample_otr   (sample_otr),
      .overrun      (overrun),
      .otr_count    (otr_count),
      .stat_clr     (stat_clr),
      .busy         (busy)
   );

   always #5 clk_PSRAM = ~clk_PSRAM;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_PSRAM);
      #1;
      if (adc_clk && !clk_prev && q_d.size() > 0) begin
         adc_out = q_d.pop_front();
         adc_OTR = q_o.pop_front();
      end
      clk_prev = adc_clk;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push(input int v, input logic o);
      q_d.push_back(DATA_W'(v));
      q_o.push_back(o);
   endtask

   initial begin
      rst = 1'b1; adc_enable = 1'b0; avg_en = 1'b0; adc_out = '0; adc_OTR = 1'b0;
      sample_ready = 1'b1; stat_clr = 1'b0;
      steps(2);
      check("rst_valid",  32'(sample_valid), 0);
      check("rst_data",   32'(sample_data),  0);
      check("rst_otr",    32'(sample_otr),   0);
      check("rst_adcclk", 32'(adc_clk),      0);
      check("rst_busy",   32'(busy),         0);
      check("rst_ovr",    32'(overrun),      0);
      check("rst_otrcnt", 32'(otr_count),    0);
      rst = 1'b0;

      // Averaging off, ramp 1,2,3,...
      for (int i = 1; i <= 11; i++) push(i, 1'b0);
      adc_enable = 1'b1;
      step();                                     // W0
      check("s1_busy",    32'(busy),    1);
      check("s1_clk_w0",  32'(adc_clk), 1);
      steps(5);                                   // W5
      check("s1_clk_w5",  32'(adc_clk), 0);
      steps(5);                                   // W10
      check("s1_clk_w10", 32'(adc_clk), 1);
      steps(79);                                  // W89
      check("s1_vld_w89", 32'(sample_valid), 0);
      step();                                     // W90
      check("s1_vld_w90", 32'(sample_valid), 1);
      check("s1_dat_w90", 32'(sample_data),  9);
      check("s1_otr_w90", 32'(sample_otr),   0);
      step();                                     // W91
      check("s1_vld_w91", 32'(sample_valid), 0);
      steps(9);                                   // W100
      check("s1_vld_w100", 32'(sample_valid), 1);
      check("s1_dat_w100", 32'(sample_data),  10);
      adc_enable = 1'b0;
      step();
      check("s1_idle_busy", 32'(busy),    0);
      check("s1_idle_clk",  32'(adc_clk), 0);

      // Averaging on: warmup OTRs ignored, windows 0xFFF, 250, 5, 7
      q_d.delete(); q_o.delete();
      for (int i = 0; i < 8; i++) push(100, (i == 0) || (i == 7));
      for (int i = 0; i < 4; i++) push(4095, 1'b0);
      push(100, 1'b0); push(200, 1'b1); push(300, 1'b0); push(401, 1'b0);
      for (int i = 0; i < 4; i++) push(5, 1'b0);
      for (int i = 0; i < 4; i++) push(7, 1'b1);
      for (int i = 0; i < 7; i++) push(8, 1'b0);
      avg_en = 1'b1;
      adc_enable = 1'b1;
      step();                                     // W0
      avg_en = 1'b0;
      steps(119);                                 // W119
      check("s2_vld_w119", 32'(sample_valid), 0);
      step();                                     // W120
      check("s2_vld_w120", 32'(sample_valid), 1);
      check("s2_dat_w120", 32'(sample_data),  4095);
      check("s2_otr_w120", 32'(sample_otr),   0);
      steps(40);                                  // W160
      check("s2_dat_w160", 32'(sample_data),  250);
      check("s2_otr_w160", 32'(sample_otr),   1);
      check("s2_cnt_w160", 32'(otr_count),    1);
      steps(40);                                  // W200
      check("s2_dat_w200", 32'(sample_data),  5);
      check("s2_otr_w200", 32'(sample_otr),   0);
      steps(10);                                  // W210
      check("s2_cnt_w210", 32'(otr_count),    2);
      steps(10);                                  // W220
      check("s2_cnt_w220", 32'(otr_count),    3);
      steps(20);                                  // W240
      check("s2_dat_w240", 32'(sample_data),  7);
      check("s2_otr_w240", 32'(sample_otr),   1);
      check("s2_cnt_sat",  32'(otr_count),    3);

      // Back-pressure: 7 held, next result (8) dropped
      sample_ready = 1'b0;
      steps(39);                                  // W279
      check("s3_vld_w279", 32'(sample_valid), 1);
      check("s3_ovr_w279", 32'(overrun),      0);
      step();                                     // W280
      check("s3_dat_hold", 32'(sample_data),  7);
      check("s3_otr_hold", 32'(sample_otr),   1);
      check("s3_ovr_set",  32'(overrun),      1);
      stat_clr = 1'b1;
      step();                                     // W281
      stat_clr = 1'b0;
      check("s3_ovr_clr",  32'(overrun),      0);
      check("s3_cnt_clr",  32'(otr_count),    0);
      check("s3_vld_keep", 32'(sample_valid), 1);

      // Disable mid-window with a held sample
      steps(19);                                  // W300
      adc_enable = 1'b0;
      step();                                     // W301
      check("s4_busy",     32'(busy),         0);
      check("s4_adcclk",   32'(adc_clk),      0);
      check("s4_vld_held", 32'(sample_valid), 1);
      check("s4_dat_held", 32'(sample_data),  7);
      sample_ready = 1'b1;
      step();
      check("s4_vld_acc",  32'(sample_valid), 0);

      // Re-enable: full warmup again, stale partial window must be gone
      q_d.delete(); q_o.delete();
      for (int i = 0; i < 8; i++) push(100, 1'b0);
      push(4, 1'b0); push(4, 1'b1); push(4, 1'b0); push(4, 1'b0);
      avg_en = 1'b1;
      adc_enable = 1'b1;
      step();                                     // W0'
      check("s5_busy",     32'(busy),         1);
      steps(119);                                 // W119'
      check("s5_vld_w119", 32'(sample_valid), 0);
      check("s5_cnt",      32'(otr_count),    1);
      step();                                     // W120'
      check("s5_vld_w120", 32'(sample_valid), 1);
      check("s5_dat_w120", 32'(sample_data),  4);
      check("s5_otr_w120", 32'(sample_otr),   1);

      // Reset in RUN with a sample pending
      sample_ready = 1'b0;
      adc_enable = 1'b0;
      rst = 1'b1;
      step();
      check("s6_valid",  32'(sample_valid), 0);
      check("s6_data",   32'(sample_data),  0);
      check("s6_otr",    32'(sample_otr),   0);
      check("s6_adcclk", 32'(adc_clk),      0);
      check("s6_busy",   32'(busy),         0);
      check("s6_ovr",    32'(overrun),      0);
      check("s6_otrcnt", 32'(otr_count),    0);
      rst = 1'b0;
      step();
      check("s6_idle",   32'(busy),         0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Parametrised single-clock successor to the ADC sampling block. Generates the ADC conversion clock by dividing the system clock, discards the converter's pipeline-latency samples, and captures data at a fixed settled phase. Optionally box-car averages 2^AVG_LOG2 samples. Delivers samples over a valid/ready handshake with overrun and out-of-range statistics. Sits between the external ADC pins and the PSRAM write path.

Parameters:
CLK, 60, system clock frequency in MHz
ADC_FREQ, 6, ADC sample clock frequency in MHz; DIV = CLK/ADC_FREQ must be even and >= 2 (elaboration error otherwise)
DATA_W, 12, ADC data width
PIPE_DELAY, 8, number of samples discarded after each enable
AVG_LOG2, 2, log2 of the averaging window (0 allowed: window of 1)
OTR_CNT_W, 16, width of the OTR counter

Ports:
clk_PSRAM  in  1  system clock; everything is synchronous to its rising edge
rst  in  1  synchronous, active-high reset
adc_enable  in  1  run request
avg_en  in  1  averaging mode; latched on the IDLE->WARMUP transition
adc_out  in  DATA_W  ADC parallel data
adc_OTR  in  1  ADC out-of-range flag
adc_clk  out  1  generated ADC conversion clock
sample_valid  out  1  output sample pending
sample_ready  in  1  consumer accepts the sample
sample_data  out  DATA_W  sample or average
sample_otr  out  1  OTR seen in any sample contributing to sample_data
overrun  out  1  sticky: a sample was dropped
otr_count  out  OTR_CNT_W  saturating count of captured (non-discarded) samples with OTR
stat_clr  in  1  clears overrun and otr_count
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, div_cnt=0, adc_clk=0, sample_valid=0, sample_data=0, sample_otr=0, overrun=0, otr_count=0, busy=0, accumulator=0.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE -> WARMUP when adc_enable=1; latch avg_en, clear the discard counter and the accumulator.
  - WARMUP -> RUN after PIPE_DELAY ticks.
  - WARMUP/RUN -> IDLE on the cycle after adc_enable is seen low: div_cnt=0, adc_clk=0, accumulator cleared, partial window lost.
  - If PIPE_DELAY=0, the first tick is captured.
- Divider: in WARMUP/RUN, div_cnt counts 0..DIV-1 and wraps. adc_clk is registered, =1 while div_cnt < DIV/2. The first WARMUP cycle has div_cnt=0.
- Tick: the cycle where div_cnt==DIV-1, i.e. the end of the low phase, just before the rising edge. adc_out and adc_OTR are sampled on ticks only.
  - In WARMUP a tick only increments the discard counter.
- RUN, avg off: each tick produces a result = adc_out, otr = adc_OTR.
- RUN, avg on:
  - Accumulator width DATA_W+AVG_LOG2, zero-extended add; window OTR is ORed across the window.
  - After 2^AVG_LOG2 ticks, result = sum[DATA_W+AVG_LOG2-1:AVG_LOG2] (truncating), otr = window OR. The accumulator restarts at the next sample.
- Result delivery, single holding register, 1 cycle after the tick:
  - If sample_valid=0, or sample_valid&&sample_ready in the same cycle: load the result, sample_valid=1.
  - Else drop the new result, keep the held one, set overrun=1.
- Handshake:
  - Transfer occurs when sample_valid&&sample_ready; sample_valid falls next cycle unless reloaded.
  - sample_data and sample_otr are stable while sample_valid=1.
  - A held sample survives adc_enable going low and stays until accepted.
- otr_count: +1 per RUN tick with adc_OTR=1, saturates at all-ones.
  - stat_clr has priority over a simultaneous increment or overrun set; the register becomes 0.
- rst mid-operation returns everything to reset values, including a held sample.

Decomposition:
- Package adc_pkg: state encoding (IDLE/WARMUP/RUN), DIV derivation function, and the parameter legality check.
- One sub-module is natural: adc_clk_div (div_cnt, adc_clk, tick output; enable input). FSM, accumulator and holding register stay in the top.

Test Plan:
- CLK=60, ADC_FREQ=6 (DIV=10), PIPE_DELAY=8, avg off, adc_out ramp 1,2,3… changing after each adc_clk rise, sample_ready=1 -> adc_clk period 10 cycles, 50% duty; ticks at W9+10k; first sample_valid at W90 with the 9th value, then one sample every 10 cycles.
- avg on, AVG_LOG2=2, adc_out constant 0xFFF after warmup, then 100,200,300,401 -> first result 0xFFF; next result 250 (1001>>2); no overflow.
- sample_ready=0 across two results -> first result held unchanged, second dropped, overrun=1; stat_clr pulse -> overrun=0 next cycle.
- adc_OTR=1 on exactly 3 RUN ticks, one of them inside an avg window -> otr_count=3, that window's sample_otr=1, other windows 0; OTR_CNT_W=2 with 5 OTR ticks -> saturates at 3.
- adc_enable low mid-window with a sample held -> IDLE, adc_clk=0, busy=0, held sample still valid until ready; re-enable -> warmup repeats 8 discarded ticks.
- rst asserted in RUN with sample_valid=1 -> next cycle all outputs at reset values.
